jtag_tap_controller: RTL and testbench
======================================

# jtag_tap_controller

- IEEE 1149.1-style TAP controller that drives the ripple-adder boundary scan chain.
- Decodes TCK/TMS into the 16-state TAP state machine and holds a 4-bit instruction register.
- Generates the chain controls ShiftDR, ClockDR, UpdateDR and Mode, and muxes the serial data paths onto TDO.
- Sits between the chip JTAG pins and the boundary scan chain; the chain's serial output returns as bsc_tdo.

## Interface
- IR_W, 4, instruction register width.
- IDCODE_VALUE, 32'h1ADD_0001, device ID; bit 0 must be 1.
- Clock and reset (already decided): one clock, TCK; reset TRST_n is asynchronous, active-low.
- TCK  in  1  test clock; both edges used.
- TRST_n  in  1  async active-low reset.
- TMS  in  1  mode select, sampled on rising TCK.
- TDI  in  1  serial data in; forwarded to the chain and the internal registers.
- bsc_tdo  in  1  serial output of the boundary scan chain.
- ShiftDR  out  1  chain shift enable.
- ClockDR  out  1  gated TCK for chain capture/shift flops.
- UpdateDR  out  1  chain update strobe.
- Mode  out  1  chain output-mux select; 1 = test data drives pins.
- TDO  out  1  serial data out.
- TDO_en  out  1  TDO driver enable.
- tap_state  out  4  current TAP state, for debug.

## Operation
- **States and encoding:** TestLogicReset=F, RunTestIdle=C, SelectDR=7, CaptureDR=6, ShiftDR=2, Exit1DR=1, PauseDR=3, Exit2DR=0, UpdateDR=5, SelectIR=4, CaptureIR=E, ShiftIR=A, Exit1IR=9, PauseIR=B, Exit2IR=8, UpdateIR=D.
- **Transitions:** standard 1149.1 TMS arcs, taken on rising TCK. From any state, five consecutive TMS=1 reach TestLogicReset.
- **Instructions:**
  - EXTEST=4'b0000 selects the boundary chain, Mode=1.
  - SAMPLE=4'b0001 selects the boundary chain, Mode=0.
  - IDCODE=4'b0010 selects the ID register.
  - BYPASS=4'b1111 selects the bypass register.
  - Any other code decodes as BYPASS.
- **IR:**
  - CaptureIR loads shift stage with 4'b0101.
  - ShiftIR shifts LSB-first: TDI enters the MSB, TDO = stage bit 0.
  - UpdateIR copies the shift stage into the active IR on falling TCK.
  - TestLogicReset forces the active IR to IDCODE (BYPASS when the ID register is compiled out).
- **Bypass register:** 1 bit; CaptureDR loads 0; ShiftDR loads TDI.
- **ID register:** 32 bits; CaptureDR loads IDCODE_VALUE; ShiftDR shifts right with TDI into bit 31.
- **ClockDR:** ClockDR = TCK AND gate. Gate is registered on falling TCK, set when the next state is CaptureDR or ShiftDR with the boundary chain selected. Glitch-free, no latch.
- **TDO mux:**
  - ShiftIR: IR bit 0.
  - ShiftDR: bsc_tdo, bypass bit or ID bit 0, per the selected register.
  - Otherwise TDO=0.
- Mode is combinational from the active IR and holds through every state except TestLogicReset.

## Timing
- **State register:** updates on rising TCK.
- **Falling-TCK outputs:** ShiftDR, UpdateDR, TDO, TDO_en and the IR update.
- **ShiftDR:** high from the falling edge in ShiftDR state until the falling edge after leaving it.
- **UpdateDR:** high for exactly one TCK period, from the falling edge in UpdateDR state.
- **Reset values:** TRST_n low forces, immediately:
  - state=TestLogicReset (tap_state=4'hF), IR=IDCODE;
  - ShiftDR=0, UpdateDR=0, Mode=0, ClockDR gate=0;
  - TDO=0, TDO_en=0, bypass=0.
- **Reset mid-shift:** partially shifted IR/DR contents are discarded and the active IR is not updated.
- **Pause states:** shift registers hold their value; ClockDR is gated off.
- **Latency, N-bit DR shift:** N rising TCK edges in ShiftDR; the first TDO bit is valid after the falling edge following CaptureDR→ShiftDR.
- **Bypass:** adds exactly one TCK of TDI→TDO delay.

## Configuration
- Macro: JTAG_IDCODE_EN.
- **Defined:**
  - 32-bit ID register is present.
  - IDCODE instruction is valid.
  - Reset instruction is IDCODE.
- **Undefined:**
  - No ID register is built and IDCODE_VALUE is unused.
  - Code 4'b0010 decodes as BYPASS.
  - Reset instruction is BYPASS; a DR scan right after reset returns 0 then delayed TDI.

## Test plan
- **Async reset:** TRST_n=0 mid-ShiftDR → tap_state=4'hF, ShiftDR=0, TDO_en=0, Mode=0 with no TCK edge.
- **Sync reset:** TMS=1 for 5 rising edges from PauseIR → tap_state=4'hF; one extra TMS=1 edge keeps 4'hF.
- **IDCODE read after reset:** TMS 0,1,0,0 then 32 ShiftDR cycles → TDO emits 32'h1ADD_0001 LSB-first; IR capture read in a later IR scan returns 4'b0101.
- **BYPASS:** load 4'b1111, shift DR with TDI=1,0,1,1 → TDO=0,1,0,1.
- **EXTEST:** load 4'b0000 → Mode=1 after the UpdateIR falling edge. A 51-bit DR scan yields:
  - exactly 52 ClockDR rising edges (1 capture + 51 shift);
  - bsc_tdo on TDO;
  - a single one-TCK UpdateDR pulse.
- **Undefined code and macro off:** load 4'b0110 → behaves as BYPASS (one-cycle TDI→TDO delay). With JTAG_IDCODE_EN undefined, a post-reset DR scan returns 0 first.

Source files
------------

// File: rtl/jtag_tap_controller_if.sv
// Pin-side and chain-side signals of the JTAG TAP controller.
// slave = the TAP itself; master = whatever drives the pins and returns the chain output.
interface jtag_tap_controller_if;
  logic       TMS;
  logic       TDI;
  logic       bsc_tdo;
  logic       ShiftDR;
  logic       ClockDR;
  logic       UpdateDR;
  logic       Mode;
  logic       TDO;
  logic       TDO_en;
  logic [3:0] tap_state;

  modport slave (
    input  TMS, TDI, bsc_tdo,
    output ShiftDR, ClockDR, UpdateDR, Mode, TDO, TDO_en, tap_state
  );

  modport master (
    output TMS, TDI, bsc_tdo,
    input  ShiftDR, ClockDR, UpdateDR, Mode, TDO, TDO_en, tap_state
  );
endinterface

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1-style TAP controller driving the ripple-adder boundary scan chain.
// Optional 32-bit ID register and IDCODE instruction: define JTAG_IDCODE_EN.
module jtag_tap_controller #(
  parameter int          IR_W         = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1ADD_0001
) (
  input  logic                 TCK,
  input  logic                 TRST_n,
  jtag_tap_controller_if.slave jtag
);

  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SH_DR    = 4'h2,
    EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR   = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SH_IR    = 4'hA,
    EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR   = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_t;

  localparam logic [IR_W-1:0] IR_EXTEST  = '0;
  localparam logic [IR_W-1:0] IR_SAMPLE  = IR_W'(1);
  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(5);
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(2);
  localparam logic [IR_W-1:0] IR_RESET   = IR_IDCODE;
`else
  // Without the ID register the reset instruction is BYPASS (all ones).
  localparam logic [IR_W-1:0] IR_RESET   = '1;
  if (IDCODE_VALUE[0] != 1'b1) begin : g_idcode_lsb_clear
  end
`endif

  tap_state_t      r_state;
  tap_state_t      w_next;
  logic [IR_W-1:0] r_ir_shift;
  logic [IR_W-1:0] r_ir;
  logic            r_bypass;
  logic            r_tdo;
  logic            r_tdo_en;
  logic            r_shift_dr;
  logic            r_update_dr;
  logic            r_gate;
  logic            w_sel_bsc;
  logic            w_tdo_next;
`ifdef JTAG_IDCODE_EN
  logic [31:0]     r_id;
  logic            w_sel_id;
`endif

  // State register, rising TCK.
  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) r_state <= TLR;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      TLR:      w_next = jtag.TMS ? TLR    : RTI;
      RTI:      w_next = jtag.TMS ? SEL_DR : RTI;
      SEL_DR:   w_next = jtag.TMS ? SEL_IR : CAP_DR;
      CAP_DR:   w_next = jtag.TMS ? EX1_DR : SH_DR;
      SH_DR:    w_next = jtag.TMS ? EX1_DR : SH_DR;
      EX1_DR:   w_next = jtag.TMS ? UPD_DR : PAUSE_DR;
      PAUSE_DR: w_next = jtag.TMS ? EX2_DR : PAUSE_DR;
      EX2_DR:   w_next = jtag.TMS ? UPD_DR : SH_DR;
      UPD_DR:   w_next = jtag.TMS ? SEL_DR : RTI;
      SEL_IR:   w_next = jtag.TMS ? TLR    : CAP_IR;
      CAP_IR:   w_next = jtag.TMS ? EX1_IR : SH_IR;
      SH_IR:    w_next = jtag.TMS ? EX1_IR : SH_IR;
      EX1_IR:   w_next = jtag.TMS ? UPD_IR : PAUSE_IR;
      PAUSE_IR: w_next = jtag.TMS ? EX2_IR : PAUSE_IR;
      EX2_IR:   w_next = jtag.TMS ? UPD_IR : SH_IR;
      UPD_IR:   w_next = jtag.TMS ? SEL_DR : RTI;
      default:  w_next = TLR;
    endcase
  end

  // Instruction decode; anything not recognised falls through to bypass.
  always_comb begin
    w_sel_bsc = (r_ir == IR_EXTEST) || (r_ir == IR_SAMPLE);
`ifdef JTAG_IDCODE_EN
    w_sel_id  = (r_ir == IR_IDCODE);
`endif
  end

  always_comb begin
    w_tdo_next = 1'b0;
    if (r_state == SH_IR) begin
      w_tdo_next = r_ir_shift[0];
    end else if (r_state == SH_DR) begin
      if (w_sel_bsc)     w_tdo_next = jtag.bsc_tdo;
`ifdef JTAG_IDCODE_EN
      else if (w_sel_id) w_tdo_next = r_id[0];
`endif
      else               w_tdo_next = r_bypass;
    end
  end

  // Capture/shift stages act on rising TCK while in the capture/shift states.
  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      r_ir_shift <= '0;
      r_bypass   <= 1'b0;
    end else begin
      if (r_state == CAP_IR)     r_ir_shift <= IR_CAPTURE;
      else if (r_state == SH_IR) r_ir_shift <= {jtag.TDI, r_ir_shift[IR_W-1:1]};
      if (r_state == CAP_DR)     r_bypass   <= 1'b0;
      else if (r_state == SH_DR) r_bypass   <= jtag.TDI;
    end
  end

`ifdef JTAG_IDCODE_EN
  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      r_id <= '0;
    end else if (w_sel_id) begin
      if (r_state == CAP_DR)     r_id <= IDCODE_VALUE;
      else if (r_state == SH_DR) r_id <= {jtag.TDI, r_id[31:1]};
    end
  end
`endif

  // Falling-TCK outputs. The ClockDR gate changes only while TCK is low,
  // so TCK & r_gate cannot glitch.
  always_ff @(negedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      r_ir        <= IR_RESET;
      r_tdo       <= 1'b0;
      r_tdo_en    <= 1'b0;
      r_shift_dr  <= 1'b0;
      r_update_dr <= 1'b0;
      r_gate      <= 1'b0;
    end else begin
      r_tdo       <= w_tdo_next;
      r_tdo_en    <= (r_state == SH_IR) || (r_state == SH_DR);
      r_shift_dr  <= (r_state == SH_DR);
      r_update_dr <= (r_state == UPD_DR);
      r_gate      <= w_sel_bsc && ((w_next == CAP_DR) || (w_next == SH_DR));
      if (r_state == TLR)         r_ir <= IR_RESET;
      else if (r_state == UPD_IR) r_ir <= r_ir_shift;
    end
  end

  assign jtag.ClockDR   = TCK & r_gate;
  assign jtag.ShiftDR   = r_shift_dr;
  assign jtag.UpdateDR  = r_update_dr;
  assign jtag.Mode      = (r_ir == IR_EXTEST) && (r_state != TLR);
  assign jtag.TDO       = r_tdo;
  assign jtag.TDO_en    = r_tdo_en;
  assign jtag.tap_state = r_state;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Randomized bench for jtag_tap_controller: a table-driven TAP model checked
// every half TCK period, plus directed scans with literal expectations.
module tb_jtag_tap_controller;

  logic TCK    = 1'b0;
  logic TRST_n = 1'b1;

  jtag_tap_controller_if bus ();

  jtag_tap_controller #(
    .IR_W(4),
    .IDCODE_VALUE(32'h1ADD_0001)
  ) dut (
    .TCK(TCK),
    .TRST_n(TRST_n),
    .jtag(bus)
  );

  always #5 TCK = ~TCK;

  // ---------------- scoreboard counters ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  localparam logic [3:0] S_TLR = 4'hF, S_CAPDR = 4'h6, S_SHDR = 4'h2, S_UPDDR = 4'h5;
  localparam logic [3:0] S_CAPIR = 4'hE, S_SHIR = 4'hA, S_UPDIR = 4'hD;
`ifdef JTAG_IDCODE_EN
  localparam logic [3:0] RESET_IR = 4'b0010;
`else
  localparam logic [3:0] RESET_IR = 4'b1111;
`endif

  logic [3:0]  nxt0 [16];
  logic [3:0]  nxt1 [16];
  logic [3:0]  m_state, m_ir_sh, m_ir, m_nx;
  logic        m_byp, m_tdo, m_tdo_en, m_shdr, m_upd, m_gate;
  logic [31:0] m_id;
  int          m_sel;

  // 0 = boundary chain, 1 = ID register, 2 = bypass
  function automatic int reg_of(input logic [3:0] ir);
    if (ir == 4'b0000 || ir == 4'b0001) return 0;
`ifdef JTAG_IDCODE_EN
    if (ir == 4'b0010) return 1;
`endif
    return 2;
  endfunction

  always @(posedge TCK or negedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      m_state = S_TLR; m_ir = RESET_IR; m_byp = 1'b0; m_tdo = 1'b0;
      m_tdo_en = 1'b0; m_shdr = 1'b0; m_upd = 1'b0; m_gate = 1'b0;
    end else if (TCK) begin
      if (m_state == S_CAPIR)     m_ir_sh = 4'b0101;
      else if (m_state == S_SHIR) m_ir_sh = {bus.TDI, m_ir_sh[3:1]};
      if (m_state == S_CAPDR) begin
        m_byp = 1'b0; m_id = 32'h1ADD_0001;
      end else if (m_state == S_SHDR) begin
        m_byp = bus.TDI; m_id = {bus.TDI, m_id[31:1]};
      end
      m_state = bus.TMS ? nxt1[m_state] : nxt0[m_state];
    end else begin
      m_sel = reg_of(m_ir);
      if (m_state == S_SHIR)      m_tdo = m_ir_sh[0];
      else if (m_state == S_SHDR) m_tdo = (m_sel == 0) ? bus.bsc_tdo : (m_sel == 1) ? m_id[0] : m_byp;
      else                        m_tdo = 1'b0;
      m_tdo_en = (m_state == S_SHIR) || (m_state == S_SHDR);
      m_shdr   = (m_state == S_SHDR);
      m_upd    = (m_state == S_UPDDR);
      m_nx     = bus.TMS ? nxt1[m_state] : nxt0[m_state];
      m_gate   = (m_sel == 0) && (m_nx == S_CAPDR || m_nx == S_SHDR);
      if (m_state == S_TLR)        m_ir = RESET_IR;
      else if (m_state == S_UPDIR) m_ir = m_ir_sh;
    end
  end

  // ---------------- per-half-cycle compare ----------------
  always @(TCK) begin
    #1;
    if (TRST_n) begin
      check("tap_state", bus.tap_state, m_state);
      check("tdo", bus.TDO, m_tdo);
      check("tdo_en", bus.TDO_en, m_tdo_en);
      check("shiftdr", bus.ShiftDR, m_shdr);
      check("updatedr", bus.UpdateDR, m_upd);
      check("mode", bus.Mode, (m_ir == 4'b0000) && (m_state != S_TLR));
      check("clockdr", bus.ClockDR, TCK ? m_gate : 1'b0);
    end
  end

  int n_clkdr = 0;
  int n_upd   = 0;
  always @(posedge bus.ClockDR) n_clkdr++;
  always @(posedge bus.UpdateDR) n_upd++;

  // ---------------- driver tasks ----------------
  logic last_tdo, last_bsc;

  // Inputs are applied in the high phase; TDO is sampled after the next falling edge,
  // then the task returns 2 units after the rising edge that consumed TMS/TDI.
  task automatic step(input logic tms, input logic tdi);
    bus.TMS     = tms;
    bus.TDI     = tdi;
    bus.bsc_tdo = 1'($urandom_range(0, 1));
    last_bsc    = bus.bsc_tdo;
    @(negedge TCK);
    #1 last_tdo = bus.TDO;
    @(posedge TCK);
    #2;
  endtask

  // Starts and ends in RunTestIdle.
  task automatic shift_dr(input int n, input logic [63:0] din,
                          output logic [63:0] dout, output logic [63:0] bscv);
    dout = '0; bscv = '0;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i]);
      dout[i] = last_tdo;
      bscv[i] = last_bsc;
    end
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  task automatic shift_ir(input logic [3:0] val, output logic [3:0] cap);
    cap = '0;
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, val[i]);
      cap[i] = last_tdo;
    end
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  task automatic goto_idle();
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  logic [63:0] din, dout, bscv;
  logic [3:0]  cap;
  int          c0, u0;

  initial begin
    nxt0[4'hF] = 4'hC; nxt1[4'hF] = 4'hF;
    nxt0[4'hC] = 4'hC; nxt1[4'hC] = 4'h7;
    nxt0[4'h7] = 4'h6; nxt1[4'h7] = 4'h4;
    nxt0[4'h6] = 4'h2; nxt1[4'h6] = 4'h1;
    nxt0[4'h2] = 4'h2; nxt1[4'h2] = 4'h1;
    nxt0[4'h1] = 4'h3; nxt1[4'h1] = 4'h5;
    nxt0[4'h3] = 4'h3; nxt1[4'h3] = 4'h0;
    nxt0[4'h0] = 4'h2; nxt1[4'h0] = 4'h5;
    nxt0[4'h5] = 4'hC; nxt1[4'h5] = 4'h7;
    nxt0[4'h4] = 4'hE; nxt1[4'h4] = 4'hF;
    nxt0[4'hE] = 4'hA; nxt1[4'hE] = 4'h9;
    nxt0[4'hA] = 4'hA; nxt1[4'hA] = 4'h9;
    nxt0[4'h9] = 4'hB; nxt1[4'h9] = 4'hD;
    nxt0[4'hB] = 4'hB; nxt1[4'hB] = 4'h8;
    nxt0[4'h8] = 4'hA; nxt1[4'h8] = 4'hD;
    nxt0[4'hD] = 4'hC; nxt1[4'hD] = 4'h7;

    bus.TMS = 1'b1; bus.TDI = 1'b0; bus.bsc_tdo = 1'b0;
    #1 TRST_n = 1'b0;
    #2;
    check("rst_state", bus.tap_state, 4'hF);
    check("rst_shiftdr", bus.ShiftDR, 1'b0);
    check("rst_updatedr", bus.UpdateDR, 1'b0);
    check("rst_mode", bus.Mode, 1'b0);
    check("rst_tdo", bus.TDO, 1'b0);
    check("rst_tdo_en", bus.TDO_en, 1'b0);
    check("rst_clockdr", bus.ClockDR, 1'b0);
    @(posedge TCK); #2 TRST_n = 1'b1;
    step(1'b0, 1'b0);

    // First DR scan after reset uses the reset instruction.
    din = {$urandom, $urandom};
    shift_dr(32, din, dout, bscv);
`ifdef JTAG_IDCODE_EN
    check("idcode_read", dout[31:0], 32'h1ADD_0001);
`else
    check("reset_dr_first", dout[0], 1'b0);
    check("reset_dr_delayed", dout[31:1], din[30:0]);
`endif

    shift_ir(4'b1111, cap);
    check("ir_capture", cap, 4'b0101);
    shift_dr(4, 64'b1101, dout, bscv);
    check("bypass_tdo", dout[3:0], 4'b1010);

    shift_ir(4'b0000, cap);
    check("extest_mode", bus.Mode, 1'b1);
    c0 = n_clkdr; u0 = n_upd;
    din = {$urandom, $urandom};
    shift_dr(51, din, dout, bscv);
    check("extest_clockdr_edges", 64'(n_clkdr - c0), 64'd52);
    check("extest_updatedr_pulses", 64'(n_upd - u0), 64'd1);
    check("extest_bsc_on_tdo", dout[50:0], bscv[50:0]);

    shift_ir(4'b0001, cap);
    check("sample_mode", bus.Mode, 1'b0);

    shift_ir(4'b0110, cap);
    shift_dr(4, 64'b1101, dout, bscv);
    check("undef_is_bypass", dout[3:0], 4'b1010);

    // Sync reset from PauseIR.
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    check("pause_ir_state", bus.tap_state, 4'hB);
    repeat (5) step(1'b1, 1'b0);
    check("sync_reset_state", bus.tap_state, 4'hF);
    step(1'b1, 1'b0);
    check("sync_reset_hold", bus.tap_state, 4'hF);
    step(1'b0, 1'b0);

    // Async reset in the middle of an EXTEST DR shift.
    shift_ir(4'b0000, cap);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1);
    check("pre_async_shiftdr", bus.ShiftDR, 1'b1);
    TRST_n = 1'b0;
    #1;
    check("async_state", bus.tap_state, 4'hF);
    check("async_shiftdr", bus.ShiftDR, 1'b0);
    check("async_tdo_en", bus.TDO_en, 1'b0);
    check("async_mode", bus.Mode, 1'b0);
    @(posedge TCK); #2 TRST_n = 1'b1;
    step(1'b0, 1'b0);

    // Randomized scans and free-running TMS, all checked by the model.
    for (int k = 0; k < 20; k++) begin
      goto_idle();
      shift_ir(4'($urandom_range(0, 15)), cap);
      din = {$urandom, $urandom};
      shift_dr($urandom_range(1, 40), din, dout, bscv);
      repeat (10) step($urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)));
    end
    repeat (400) step($urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
